// File: rtl/rx_word_assembler_pkg.sv
// Shared constants and types for the 8b10b receive word assembler.
// Holds the comma symbol, the sync state encoding and the status counter width.
package rx_word_assembler_pkg;

    localparam logic [7:0]  K28_5 = 8'hBC;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        StHunt   = 1'b0,
        StSynced = 1'b1
    } sync_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rx_word_fifo.sv
// First-word-fall-through FIFO on a synchronous-read RAM.
// The head word is prefetched into an output register, so a word written into an empty FIFO
// becomes visible (empty falls) one cycle after the write.
module rx_word_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 2048
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_drop,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_empty;

    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic [AW-1:0]    w_rd_addr;
    logic [AW:0]      w_count_after_pop;
    logic [AW:0]      w_count_next;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_pop_ok  = i_pop && !r_empty;
    assign w_push_ok = i_push && (!w_full || w_pop_ok);
    // Read address looks one word ahead on a pop so the output register tracks the new head.
    assign w_rd_addr = w_pop_ok ? r_rd_ptr + AW'(1) : r_rd_ptr;

    always_comb begin
        w_count_after_pop = r_count;
        if (w_pop_ok) begin
            w_count_after_pop = r_count - (AW+1)'(1);
        end
        w_count_next = w_count_after_pop;
        if (w_push_ok) begin
            w_count_next = w_count_after_pop + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            // Nothing older than a word written this edge means the prefetch is still stale.
            r_empty <= (w_count_after_pop == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[w_rd_addr];
        end
    end

    assign o_rdata = r_rdata;
    assign o_empty = r_empty;
    assign o_full  = w_full;
    assign o_drop  = i_push && !w_push_ok;
    assign o_count = r_count;

endmodule

// File: rtl/rx_word_assembler.sv
// Comma-based symbol sync, byte-to-word assembly and status counters for a decoded 8b10b
// stream; completed words are queued in an rx_word_fifo.
module rx_word_assembler
    import rx_word_assembler_pkg::*;
#(
    parameter int unsigned NBYTES    = 3,
    parameter int unsigned DEPTH     = 2048,
    parameter int unsigned SYNC_CNT  = 4,
    parameter int unsigned ERR_LIMIT = 8
) (
    input  logic                  WCLK,
    input  logic                  RESET,
    input  logic                  sym_valid,
    input  logic                  sym_k,
    input  logic [7:0]            sym_data,
    input  logic                  sym_err,
    input  logic                  enable_rx,
    input  logic                  read,
    output logic [8*NBYTES-1:0]   data,
    output logic                  empty,
    output logic                  full,
    output logic                  rec_sync_ready,
    output logic [CNT_W-1:0]      lost_data_cnt,
    output logic [CNT_W-1:0]      decoder_err_cnt,
    output logic [CNT_W-1:0]      frame_err_cnt,
    output logic [15:0]           fifo_size
);

    localparam int unsigned WW    = 8 * NBYTES;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned IDX_W = 4;

    sync_state_e        r_state;
    logic [3:0]         r_comma_cnt;
    logic [CNT_W-1:0]   r_err_run;
    logic [IDX_W-1:0]   r_idx;
    logic [WW-1:0]      r_word;
    logic               r_push;
    logic [CNT_W-1:0]   r_lost_cnt;
    logic [CNT_W-1:0]   r_derr_cnt;
    logic [CNT_W-1:0]   r_ferr_cnt;

    sync_state_e        w_state_d;
    logic [3:0]         w_comma_d;
    logic [CNT_W-1:0]   w_err_run_d;
    logic [IDX_W-1:0]   w_idx_d;
    logic [WW-1:0]      w_word_d;
    logic               w_push_d;
    logic [CNT_W-1:0]   w_derr_d;
    logic [CNT_W-1:0]   w_ferr_d;

    logic               w_good_comma;
    logic               w_drop;
    logic [AW:0]        w_count;

    assign w_good_comma = sym_valid && sym_k && !sym_err && (sym_data == K28_5);

    // Sync FSM: independent of enable_rx.
    always_comb begin
        w_state_d   = r_state;
        w_comma_d   = r_comma_cnt;
        w_err_run_d = r_err_run;
        unique case (r_state)
            StHunt: begin
                if (sym_valid) begin
                    if (!w_good_comma) begin
                        w_comma_d = '0;
                    end else if (r_comma_cnt == 4'(SYNC_CNT - 1)) begin
                        w_state_d = StSynced;
                        w_comma_d = '0;
                    end else begin
                        w_comma_d = r_comma_cnt + 4'd1;
                    end
                end
            end
            StSynced: begin
                if (sym_valid) begin
                    if (!sym_err) begin
                        w_err_run_d = '0;
                    end else if (r_err_run == CNT_W'(ERR_LIMIT - 1)) begin
                        w_state_d   = StHunt;
                        w_err_run_d = '0;
                    end else begin
                        w_err_run_d = r_err_run + CNT_W'(1);
                    end
                end
            end
            default: w_state_d = StHunt;
        endcase
    end

    // Word assembly. An errored symbol also covers the sync-loss case, so dropping idx there
    // discards any partial word when sync is lost.
    always_comb begin
        w_idx_d  = r_idx;
        w_word_d = r_word;
        w_push_d = 1'b0;
        w_derr_d = r_derr_cnt;
        w_ferr_d = r_ferr_cnt;
        if (!enable_rx) begin
            w_idx_d = '0;
        end else if (sym_valid && sym_err) begin
            w_derr_d = sat_inc(r_derr_cnt);
            w_idx_d  = '0;
        end else if (sym_valid && (r_state == StSynced)) begin
            if (sym_k) begin
                if (r_idx != '0) begin
                    w_ferr_d = sat_inc(r_ferr_cnt);
                    w_idx_d  = '0;
                end
            end else begin
                for (int unsigned b = 0; b < NBYTES; b++) begin
                    if (r_idx == IDX_W'(b)) begin
                        w_word_d[8*(NBYTES-1-b) +: 8] = sym_data;
                    end
                end
                if (r_idx == IDX_W'(NBYTES - 1)) begin
                    w_idx_d  = '0;
                    w_push_d = 1'b1;
                end else begin
                    w_idx_d = r_idx + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge WCLK) begin
        if (RESET) begin
            r_state     <= StHunt;
            r_comma_cnt <= '0;
            r_err_run   <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_push      <= 1'b0;
            r_lost_cnt  <= '0;
            r_derr_cnt  <= '0;
            r_ferr_cnt  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_comma_cnt <= w_comma_d;
            r_err_run   <= w_err_run_d;
            r_idx       <= w_idx_d;
            r_word      <= w_word_d;
            r_push      <= w_push_d;
            r_derr_cnt  <= w_derr_d;
            r_ferr_cnt  <= w_ferr_d;
            if (w_drop) begin
                r_lost_cnt <= sat_inc(r_lost_cnt);
            end
        end
    end

    rx_word_fifo #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (WCLK),
        .i_rst   (RESET),
        .i_push  (r_push),
        .i_wdata (r_word),
        .i_pop   (read),
        .o_rdata (data),
        .o_empty (empty),
        .o_full  (full),
        .o_drop  (w_drop),
        .o_count (w_count)
    );

    assign rec_sync_ready  = (r_state == StSynced);
    assign lost_data_cnt   = r_lost_cnt;
    assign decoder_err_cnt = r_derr_cnt;
    assign frame_err_cnt   = r_ferr_cnt;
    assign fifo_size       = 16'(w_count);

endmodule

// File: tb/tb_rx_word_assembler.sv
// Self-checking bench: instance 0 (NBYTES=3, DEPTH=4) is driven from a vector table plus
// hand sequences; instances 1 (NBYTES=1) and 2 (NBYTES=4) run a scoreboard wrap test.
module tb_rx_word_assembler;

    logic WCLK = 1'b0;
    logic RESET;
    always #5 WCLK = ~WCLK;

    logic [2:0]  sv, sk, se, en, rd;
    logic [7:0]  sd [3];
    logic [2:0]  empty_v, full_v, sync_v;
    logic [7:0]  lost_c [3];
    logic [7:0]  derr_c [3];
    logic [7:0]  ferr_c [3];
    logic [15:0] size_c [3];
    logic [23:0] data_a;
    logic [7:0]  data_b;
    logic [31:0] data_c;
    logic [31:0] data_x [3];

    assign data_x[0] = {8'h00, data_a};
    assign data_x[1] = {24'h0, data_b};
    assign data_x[2] = data_c;

    rx_word_assembler #(.NBYTES(3), .DEPTH(4), .SYNC_CNT(4), .ERR_LIMIT(8)) u_dut_a (
        .WCLK(WCLK), .RESET(RESET), .sym_valid(sv[0]), .sym_k(sk[0]), .sym_data(sd[0]),
        .sym_err(se[0]), .enable_rx(en[0]), .read(rd[0]), .data(data_a), .empty(empty_v[0]),
        .full(full_v[0]), .rec_sync_ready(sync_v[0]), .lost_data_cnt(lost_c[0]),
        .decoder_err_cnt(derr_c[0]), .frame_err_cnt(ferr_c[0]), .fifo_size(size_c[0])
    );

    rx_word_assembler #(.NBYTES(1), .DEPTH(4), .SYNC_CNT(4), .ERR_LIMIT(8)) u_dut_b (
        .WCLK(WCLK), .RESET(RESET), .sym_valid(sv[1]), .sym_k(sk[1]), .sym_data(sd[1]),
        .sym_err(se[1]), .enable_rx(en[1]), .read(rd[1]), .data(data_b), .empty(empty_v[1]),
        .full(full_v[1]), .rec_sync_ready(sync_v[1]), .lost_data_cnt(lost_c[1]),
        .decoder_err_cnt(derr_c[1]), .frame_err_cnt(ferr_c[1]), .fifo_size(size_c[1])
    );

    rx_word_assembler #(.NBYTES(4), .DEPTH(4), .SYNC_CNT(4), .ERR_LIMIT(8)) u_dut_c (
        .WCLK(WCLK), .RESET(RESET), .sym_valid(sv[2]), .sym_k(sk[2]), .sym_data(sd[2]),
        .sym_err(se[2]), .enable_rx(en[2]), .read(rd[2]), .data(data_c), .empty(empty_v[2]),
        .full(full_v[2]), .rec_sync_ready(sync_v[2]), .lost_data_cnt(lost_c[2]),
        .decoder_err_cnt(derr_c[2]), .frame_err_cnt(ferr_c[2]), .fifo_size(size_c[2])
    );

    typedef struct {
        bit          v, k;
        logic [7:0]  d;
        bit          e, enb, r;
        bit          x_sync, x_empty;
        int          x_size;
        logic [23:0] x_data;
        int          x_ferr, x_derr;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge WCLK);
        #1;
    endtask

    task automatic step(input int u, input bit v, input bit k, input logic [7:0] d,
                        input bit e, input bit enb, input bit r);
        sv[u] = v; sk[u] = k; sd[u] = d; se[u] = e; en[u] = enb; rd[u] = r;
        tick();
        sv[u] = 1'b0; sk[u] = 1'b0; sd[u] = 8'h00; se[u] = 1'b0; en[u] = 1'b1; rd[u] = 1'b0;
    endtask

    task automatic comma(input int u);      step(u, 1, 1, 8'hBC, 0, 1, 0); endtask
    task automatic put(input int u, input logic [7:0] b); step(u, 1, 0, b, 0, 1, 0); endtask
    task automatic errsym(input int u);     step(u, 1, 0, 8'h00, 1, 1, 0); endtask
    task automatic idle(input int u);       step(u, 0, 0, 8'h00, 0, 1, 0); endtask

    task automatic sync_up(input int u);
        repeat (4) comma(u);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    task automatic pop_check(input int u, input logic [31:0] exp, input string name);
        check({name, " empty"}, 32'(empty_v[u]), 32'd0);
        check({name, " data"}, data_x[u], exp);
        step(u, 0, 0, 8'h00, 0, 1, 1);
    endtask

    task automatic add(input bit v, input bit k, input logic [7:0] d, input bit e,
                       input bit enb, input bit r, input bit xs, input bit xe, input int xz,
                       input logic [23:0] xd, input int xf, input int xdr);
        vec_t t;
        t.v = v; t.k = k; t.d = d; t.e = e; t.enb = enb; t.r = r;
        t.x_sync = xs; t.x_empty = xe; t.x_size = xz; t.x_data = xd;
        t.x_ferr = xf; t.x_derr = xdr;
        tbl.push_back(t);
    endtask

    task automatic scoreboard_run(input int u, input int nb);
        logic [31:0] q[$];
        logic [31:0] w;
        logic [7:0]  b;
        sync_up(u);
        check($sformatf("u%0d sync", u), 32'(sync_v[u]), 32'd1);
        for (int n = 0; n < 12; n++) begin
            w = 32'h0;
            for (int j = 0; j < nb; j++) begin
                b = 8'(n * 16 + j + 1);
                w = (w << 8) | 32'(b);
                put(u, b);
            end
            idle(u);
            idle(u);
            q.push_back(w);
            check($sformatf("u%0d w%0d size", u, n), 32'(size_c[u]), 32'(q.size()));
            if (n % 4 != 0) begin
                pop_check(u, q[0], $sformatf("u%0d w%0d pop", u, n));
                void'(q.pop_front());
                check($sformatf("u%0d w%0d size after pop", u, n), 32'(size_c[u]),
                      32'(q.size()));
            end
        end
        while (q.size() > 0) begin
            pop_check(u, q[0], $sformatf("u%0d drain", u));
            void'(q.pop_front());
        end
        check($sformatf("u%0d final empty", u), 32'(empty_v[u]), 32'd1);
        check($sformatf("u%0d final size", u), 32'(size_c[u]), 32'd0);
        check($sformatf("u%0d lost", u), 32'(lost_c[u]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sv = '0; sk = '0; se = '0; en = '1; rd = '0;
        for (int i = 0; i < 3; i++) sd[i] = 8'h00;

        // Reset values from the first edge with RESET high.
        RESET = 1'b1;
        tick();
        check("rst sync", 32'(sync_v[0]), 32'd0);
        check("rst empty", 32'(empty_v[0]), 32'd1);
        check("rst full", 32'(full_v[0]), 32'd0);
        check("rst size", 32'(size_c[0]), 32'd0);
        check("rst data", data_x[0], 32'd0);
        tick();
        RESET = 1'b0;

        // v k d e en rd | sync empty size data ferr derr
        repeat (3) add(1, 1, 8'hBC, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 8'h11, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        repeat (3) add(1, 1, 8'hBC, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 8'hBC, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        add(1, 0, 8'hAA, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        add(1, 0, 8'hBB, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        add(1, 0, 8'hCC, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 1, 0, 1, 24'hAABBCC, 0, 0);
        add(0, 0, 8'h00, 0, 1, 1, 1, 1, 0, 0, 0, 0);
        add(1, 0, 8'h01, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        add(1, 0, 8'h02, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        add(1, 1, 8'hBC, 0, 1, 0, 1, 1, 0, 0, 1, 0);
        add(1, 0, 8'h10, 0, 1, 0, 1, 1, 0, 0, 1, 0);
        add(1, 0, 8'h20, 0, 1, 0, 1, 1, 0, 0, 1, 0);
        add(1, 0, 8'h30, 0, 1, 0, 1, 1, 0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 1, 0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 8'h00, 0, 1, 0, 1, 0, 1, 24'h102030, 1, 0);
        add(0, 0, 8'h00, 0, 1, 1, 1, 1, 0, 0, 1, 0);
        add(1, 0, 8'h44, 0, 1, 0, 1, 1, 0, 0, 1, 0);
        add(1, 0, 8'h55, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        add(1, 0, 8'h66, 0, 1, 0, 1, 1, 0, 0, 1, 0);
        add(1, 0, 8'h77, 0, 1, 0, 1, 1, 0, 0, 1, 0);
        add(1, 0, 8'h88, 0, 1, 0, 1, 1, 0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 1, 0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 8'h00, 0, 1, 0, 1, 0, 1, 24'h667788, 1, 0);
        add(0, 0, 8'h00, 0, 1, 1, 1, 1, 0, 0, 1, 0);
        add(1, 1, 8'hBC, 0, 1, 0, 1, 1, 0, 0, 1, 0);
        add(1, 0, 8'h01, 0, 1, 0, 1, 1, 0, 0, 1, 0);
        add(1, 0, 8'h00, 1, 1, 0, 1, 1, 0, 0, 1, 1);
        add(1, 0, 8'h02, 0, 1, 0, 1, 1, 0, 0, 1, 1);
        add(1, 0, 8'h03, 0, 1, 0, 1, 1, 0, 0, 1, 1);
        add(1, 0, 8'h04, 0, 1, 0, 1, 1, 0, 0, 1, 1);
        add(0, 0, 8'h00, 0, 1, 0, 1, 1, 1, 0, 1, 1);
        add(0, 0, 8'h00, 0, 1, 0, 1, 0, 1, 24'h020304, 1, 1);
        add(0, 0, 8'h00, 0, 1, 1, 1, 1, 0, 0, 1, 1);
        add(0, 0, 8'h00, 0, 1, 1, 1, 1, 0, 0, 1, 1);

        foreach (tbl[i]) begin
            step(0, tbl[i].v, tbl[i].k, tbl[i].d, tbl[i].e, tbl[i].enb, tbl[i].r);
            check($sformatf("row%0d sync", i), 32'(sync_v[0]), 32'(tbl[i].x_sync));
            check($sformatf("row%0d empty", i), 32'(empty_v[0]), 32'(tbl[i].x_empty));
            check($sformatf("row%0d size", i), 32'(size_c[0]), 32'(tbl[i].x_size));
            check($sformatf("row%0d ferr", i), 32'(ferr_c[0]), 32'(tbl[i].x_ferr));
            check($sformatf("row%0d derr", i), 32'(derr_c[0]), 32'(tbl[i].x_derr));
            if (!tbl[i].x_empty) begin
                check($sformatf("row%0d data", i), data_x[0], 32'(tbl[i].x_data));
            end
        end

        // Error run drops sync and the partial word; counter saturates.
        do_reset();
        sync_up(0);
        check("err sync before", 32'(sync_v[0]), 32'd1);
        put(0, 8'h0A);
        repeat (7) errsym(0);
        check("err7 sync", 32'(sync_v[0]), 32'd1);
        check("err7 derr", 32'(derr_c[0]), 32'd7);
        errsym(0);
        check("err8 sync", 32'(sync_v[0]), 32'd0);
        check("err8 derr", 32'(derr_c[0]), 32'd8);
        sync_up(0);
        put(0, 8'h5A); put(0, 8'h5B); put(0, 8'h5C);
        idle(0); idle(0);
        check("resync data", data_x[0], 32'h005A5B5C);
        check("resync size", 32'(size_c[0]), 32'd1);
        check("resync ferr", 32'(ferr_c[0]), 32'd0);
        repeat (292) errsym(0);
        check("err300 derr", 32'(derr_c[0]), 32'd255);

        // Reset mid-word discards everything.
        sync_up(0);
        put(0, 8'h61); put(0, 8'h62);
        RESET = 1'b1;
        tick();
        check("midrst sync", 32'(sync_v[0]), 32'd0);
        check("midrst empty", 32'(empty_v[0]), 32'd1);
        check("midrst size", 32'(size_c[0]), 32'd0);
        check("midrst derr", 32'(derr_c[0]), 32'd0);
        check("midrst ferr", 32'(ferr_c[0]), 32'd0);
        check("midrst data", data_x[0], 32'd0);
        RESET = 1'b0;
        sync_up(0);
        put(0, 8'h71); put(0, 8'h72); put(0, 8'h73);
        idle(0); idle(0);
        check("postrst data", data_x[0], 32'h00717273);
        check("postrst ferr", 32'(ferr_c[0]), 32'd0);

        // Overflow, then simultaneous push and pop while full.
        do_reset();
        sync_up(0);
        for (int w = 1; w <= 5; w++) begin
            put(0, 8'(16 * w + 1)); put(0, 8'(16 * w + 2)); put(0, 8'(16 * w + 3));
        end
        idle(0); idle(0);
        check("ovf full", 32'(full_v[0]), 32'd1);
        check("ovf lost", 32'(lost_c[0]), 32'd1);
        check("ovf size", 32'(size_c[0]), 32'd4);
        put(0, 8'h61); put(0, 8'h62); put(0, 8'h63);
        pop_check(0, 32'h00111213, "ovf w1");
        check("pushpop size", 32'(size_c[0]), 32'd4);
        check("pushpop lost", 32'(lost_c[0]), 32'd1);
        check("pushpop full", 32'(full_v[0]), 32'd1);
        pop_check(0, 32'h00212223, "ovf w2");
        pop_check(0, 32'h00313233, "ovf w3");
        pop_check(0, 32'h00414243, "ovf w4");
        pop_check(0, 32'h00616263, "ovf w6");
        check("ovf drained empty", 32'(empty_v[0]), 32'd1);
        check("ovf drained size", 32'(size_c[0]), 32'd0);

        // Pointer wrap with interleaved reads on the other word widths.
        do_reset();
        scoreboard_run(1, 1);
        scoreboard_run(2, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rx_word_assembler.md
RX_WORD_ASSEMBLER -- requirements
Module: rx_word_assembler

Interface
REQ-001 Parameter NBYTES, default 3: decoded bytes per output word, range 1..8.
REQ-002 Parameter DEPTH, default 2048: output FIFO depth in words, power of two, range 2..32768.
REQ-003 Parameter SYNC_CNT, default 4: consecutive good commas needed to declare sync, range 1..15.
REQ-004 Parameter ERR_LIMIT, default 8: consecutive errored symbols that drop sync, range 1..255.
REQ-005 WCLK  in  1  sole clock; all logic SHALL run on its rising edge; reset is synchronous and active-high.
REQ-006 RESET  in  1  reset, synchronous to WCLK and active-high.
REQ-007 sym_valid  in  1  a decoded 8b10b symbol is present this cycle.
REQ-008 sym_k  in  1  the symbol is a control character.
REQ-009 sym_data  in  8  decoded symbol value.
REQ-010 sym_err  in  1  code or disparity error on this symbol.
REQ-011 enable_rx  in  1  permits word assembly.
REQ-012 read  in  1  pop request for the output FIFO.
REQ-013 data  out  8*NBYTES  head word of the FIFO; byte 0 occupies the MSBs.
REQ-014 empty  out  1  FIFO is empty.
REQ-015 full  out  1  FIFO holds DEPTH words.
REQ-016 rec_sync_ready  out  1  sync FSM is in SYNCED.
REQ-017 lost_data_cnt  out  8  words dropped on full, saturating.
REQ-018 decoder_err_cnt  out  8  errored symbols while enabled, saturating.
REQ-019 frame_err_cnt  out  8  partial words aborted by a K symbol, saturating.
REQ-020 fifo_size  out  16  FIFO occupancy, zero-extended.

Function
REQ-021 A "good comma" SHALL be sym_valid, sym_k=1, sym_data=8'hBC and sym_err=0.
REQ-022 The sync FSM SHALL have two states, HUNT and SYNCED; in HUNT, a good comma increments a comma counter, and any other valid symbol clears it.
REQ-023 The transition HUNT->SYNCED SHALL occur on the cycle after the comma counter reaches SYNC_CNT; the comma counter SHALL clear on entry to SYNCED.
REQ-024 In SYNCED, a valid symbol with sym_err=1 SHALL increment the consecutive-error counter, and a valid symbol with sym_err=0 SHALL clear it; reaching ERR_LIMIT SHALL cause SYNCED->HUNT, discard any partial word and clear the counter.
REQ-025 The sync FSM SHALL operate regardless of enable_rx.
REQ-026 A byte SHALL be accepted only when SYNCED, enable_rx=1, sym_valid=1, sym_k=0 and sym_err=0; it is stored at byte index idx, and idx increments.
REQ-027 When byte NBYTES-1 is accepted, the assembled word SHALL be pushed to the FIFO on the next edge, and idx SHALL return to 0; empty SHALL fall one cycle after that push.
REQ-028 A valid K symbol while SYNCED, enable_rx=1 and idx!=0 SHALL discard the partial word, set idx to 0 and increment frame_err_cnt.
REQ-029 A valid errored symbol while enable_rx=1 SHALL increment decoder_err_cnt (in either state), discard the partial word and set idx to 0.
REQ-030 enable_rx=0 SHALL hold idx at 0 and discard any partial word without counting.
REQ-031 All three counters SHALL saturate at 8'hFF.
REQ-032 The FIFO SHALL be first-word-fall-through: data is valid whenever empty=0, and read=1 with empty=0 pops one word on the same edge.
REQ-033 read=1 while empty=1 SHALL be ignored, with no state change.
REQ-034 A push while full=1 and no pop SHALL drop the word and increment lost_data_cnt.
REQ-035 A push and a pop on the same edge while full SHALL both succeed, leaving occupancy unchanged and lost_data_cnt unchanged.
REQ-036 A push and a pop on the same edge while empty SHALL leave the pushed word in the FIFO and the FIFO not empty.
REQ-037 Read and write pointers SHALL wrap modulo DEPTH.
REQ-038 fifo_size SHALL equal the occupancy register, with range 0..DEPTH.

Reset
REQ-039 RESET=1 at an edge SHALL set the FSM to HUNT and clear idx, the comma counter, the error counter, all three counters, and the FIFO pointers and occupancy.
REQ-040 Output values SHALL be rec_sync_ready=0, empty=1, full=0, fifo_size=0 and data=0 from the first edge with RESET=1.
REQ-041 Reset asserted mid-word or mid-sync SHALL discard all state with no counter side-effects.

Structure
REQ-042 A shared package/include SHALL hold the K28.5 constant (8'hBC), the HUNT/SYNCED state encoding, and the counter width (8).
REQ-043 FIFO storage and pointers SHALL be one sub-module, rx_word_fifo (parameters: width, depth), inferring block RAM; assembly, the sync FSM and the counters SHALL remain in rx_word_assembler.

Verification
REQ-044 Reset, then 4 good commas -> rec_sync_ready=1 on the cycle after the 4th; 3 commas then data 8'h11 -> stays 0.
REQ-045 Synced, bytes 8'hAA, 8'hBB, 8'hCC -> data=24'hAABBCC, empty=0 one cycle after the push, fifo_size=1; read pops -> empty=1.
REQ-046 Bytes 8'h01, 8'h02, then K28.5 -> frame_err_cnt=1, no word written; next 3 bytes form one complete word.
REQ-047 8 consecutive sym_err symbols -> decoder_err_cnt=8, rec_sync_ready=0; 300 errors -> counter holds at 255.
REQ-048 DEPTH=4: write 5 words without reads -> full=1, lost_data_cnt=1, and reads return words 1-4 in order; push+pop while full -> fifo_size remains 4.
REQ-049 NBYTES=1 and NBYTES=4 builds: wrap-around across 2*DEPTH words with interleaved reads -> data order and fifo_size match a scoreboard model.
